// File: rtl/banner_ctrl.sv
// Game-mode sequencer: selects and blinks the overlay banner, gates game logic,
// and requests level regeneration with minimum on-screen hold times in frames.
module banner_ctrl #(
    parameter int BLINK_FRAMES     = 30,
    parameter int MIN_REGEN_FRAMES = 60,
    parameter int GAME_OVER_FRAMES = 120,
    parameter int NUM_IMAGES       = 4
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic                                           i_frame_start,
    input  logic                                           i_start,
    input  logic                                           i_pause,
    input  logic                                           i_game_over,
    input  logic                                           i_lvl_complete,
    input  logic                                           i_regen_done,
    output logic [((NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1)-1:0] o_banner_num,
    output logic                                           o_banner_enbl,
    output logic                                           o_game_run,
    output logic                                           o_regen_start
);

    localparam int BANNER_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;

    localparam int CNT_MAX_A = (MIN_REGEN_FRAMES > GAME_OVER_FRAMES) ? MIN_REGEN_FRAMES
                                                                     : GAME_OVER_FRAMES;
    localparam int CNT_MAX_F = (CNT_MAX_A > BLINK_FRAMES) ? CNT_MAX_A : BLINK_FRAMES;
    localparam int CNT_W     = $clog2(CNT_MAX_F + 1);

    localparam logic [CNT_W-1:0] MIN_REGEN_CNT = CNT_W'(MIN_REGEN_FRAMES);
    localparam logic [CNT_W-1:0] GAME_OVER_CNT = CNT_W'(GAME_OVER_FRAMES);
    localparam logic [CNT_W-1:0] BLINK_LAST    = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [BANNER_W-1:0] BANNER_INIT  = BANNER_W'(0);
    localparam logic [BANNER_W-1:0] BANNER_PAUSE = BANNER_W'(1);
    localparam logic [BANNER_W-1:0] BANNER_OVER  = BANNER_W'(2);
    localparam logic [BANNER_W-1:0] BANNER_REGEN = BANNER_W'(3);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_REGEN     = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 blink_q, blink_d;
    logic                 done_q, done_d;
    logic                 regen_pend_q, regen_pend_d;
    logic [BANNER_W-1:0]  banner_q, banner_d;
    logic                 state_chg;
    logic                 blink_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_INIT;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b1;
            done_q       <= 1'b0;
            regen_pend_q <= 1'b0;
            banner_q     <= BANNER_INIT;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            done_q       <= done_d;
            regen_pend_q <= regen_pend_d;
            banner_q     <= banner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (i_start) state_d = ST_REGEN;
            end
            ST_REGEN: begin
                if (done_q && (frame_cnt_q >= MIN_REGEN_CNT)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_game_over)         state_d = ST_GAME_OVER;
                else if (i_lvl_complete) state_d = ST_REGEN;
                else if (i_pause)        state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (i_pause) state_d = ST_RUN;
            end
            ST_GAME_OVER: begin
                // Early presses are dropped outright; the player must press again.
                if (i_start && (frame_cnt_q >= GAME_OVER_CNT)) state_d = ST_INIT;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        state_chg  = (state_d != state_q);
        blink_wrap = (state_q == ST_PAUSE) && i_frame_start && (frame_cnt_q == BLINK_LAST);

        // A frame coincident with a state change is not counted in the new state.
        frame_cnt_d = frame_cnt_q;
        if (state_chg) begin
            frame_cnt_d = '0;
        end else if (blink_wrap) begin
            frame_cnt_d = '0;
        end else if (i_frame_start && (frame_cnt_q != {CNT_W{1'b1}})) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        blink_d = blink_q;
        if (state_chg && (state_d == ST_PAUSE)) begin
            blink_d = 1'b1;
        end else if (blink_wrap) begin
            blink_d = ~blink_q;
        end

        done_d = done_q;
        if (state_chg && (state_d == ST_REGEN)) begin
            done_d = 1'b0;
        end else if ((state_q == ST_REGEN) && i_regen_done) begin
            done_d = 1'b1;
        end

        regen_pend_d = state_chg && (state_d == ST_REGEN);
    end

    // Banner select is registered so RUN can keep showing whatever was last selected.
    always_comb begin
        banner_d = banner_q;
        case (state_d)
            ST_INIT:      banner_d = BANNER_INIT;
            ST_REGEN:     banner_d = BANNER_REGEN;
            ST_PAUSE:     banner_d = BANNER_PAUSE;
            ST_GAME_OVER: banner_d = BANNER_OVER;
            default:      banner_d = banner_q;
        endcase
    end

    always_comb begin
        o_banner_num  = banner_q;
        o_game_run    = (state_q == ST_RUN);
        o_regen_start = regen_pend_q;
        case (state_q)
            ST_RUN:   o_banner_enbl = 1'b0;
            ST_PAUSE: o_banner_enbl = blink_q;
            default:  o_banner_enbl = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_banner_ctrl.sv
// Scoreboard bench for banner_ctrl with short hold times so every timing rule is reachable.
module tb_banner_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       game_over = 1'b0;
    logic       lvl_complete = 1'b0;
    logic       regen_done = 1'b0;
    logic [1:0] banner_num;
    logic       banner_enbl;
    logic       game_run;
    logic       regen_start;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string tag;
        int    num;
        int    enbl;
        int    run;
        int    regen;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    banner_ctrl #(
        .BLINK_FRAMES     (2),
        .MIN_REGEN_FRAMES (4),
        .GAME_OVER_FRAMES (3),
        .NUM_IMAGES       (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_frame_start  (frame_start),
        .i_start        (start),
        .i_pause        (pause),
        .i_game_over    (game_over),
        .i_lvl_complete (lvl_complete),
        .i_regen_done   (regen_done),
        .o_banner_num   (banner_num),
        .o_banner_enbl  (banner_enbl),
        .o_game_run     (game_run),
        .o_regen_start  (regen_start)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int num, input int enbl,
                            input int run, input int regen);
        chk({tag, ".num"},   int'(banner_num),  num);
        chk({tag, ".enbl"},  int'(banner_enbl), enbl);
        chk({tag, ".run"},   int'(game_run),    run);
        chk({tag, ".regen"}, int'(regen_start), regen);
    endtask

    // Drive one cycle of pulses, queue the outputs expected after the edge, then compare.
    task automatic step(input string tag, input logic st, input logic pa, input logic go,
                        input logic lc, input logic rd, input logic fs,
                        input int num, input int enbl, input int run, input int regen);
        exp_t e;
        start        = st;
        pause        = pa;
        game_over    = go;
        lvl_complete = lc;
        regen_done   = rd;
        frame_start  = fs;
        e.tag = tag; e.num = num; e.enbl = enbl; e.run = run; e.regen = regen;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 0; pause = 0; game_over = 0; lvl_complete = 0; regen_done = 0; frame_start = 0;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk_outs(e.tag, e.num, e.enbl, e.run, e.regen);
        end
    endtask

    initial begin
        #12;
        chk_outs("in_reset", 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle_init", 0,0,0,0,0,0, 0,1,0,0);

        // INIT -> REGEN, done after one frame, hold until 4 frames counted
        step("start",      1,0,0,0,0,0, 3,1,0,1);
        step("regen_hold", 0,0,0,0,0,0, 3,1,0,0);
        step("regen_f1",   0,0,0,0,0,1, 3,1,0,0);
        step("regen_done", 0,0,0,0,1,0, 3,1,0,0);
        step("regen_f2",   0,0,0,0,0,1, 3,1,0,0);
        step("regen_f3",   0,0,0,0,0,1, 3,1,0,0);
        step("regen_f4",   0,0,0,0,0,1, 3,1,0,0);
        step("to_run",     0,0,0,0,0,0, 3,0,1,0);

        // Priority: game over wins; early start dropped
        step("all_three",  0,1,1,1,0,0, 2,1,0,0);
        step("go_f1",      0,0,0,0,0,1, 2,1,0,0);
        step("go_early",   1,0,0,0,0,0, 2,1,0,0);
        step("go_f2",      0,0,0,0,0,1, 2,1,0,0);
        step("go_f3",      0,0,0,0,0,1, 2,1,0,0);
        step("go_start",   1,0,0,0,0,0, 0,1,0,0);

        // Back to RUN with done arriving in the regen_start cycle
        step("start2",     1,0,0,0,0,0, 3,1,0,1);
        step("done_first", 0,0,0,0,1,0, 3,1,0,0);
        for (int i = 0; i < 4; i++) step("regen2_f", 0,0,0,0,0,1, 3,1,0,0);
        step("to_run2",    0,0,0,0,0,0, 3,0,1,0);

        // Pause blink with BLINK_FRAMES=2: 1,1,0,0,1
        step("pause",      0,1,0,0,0,0, 1,1,0,0);
        step("blink_f1",   0,0,0,0,0,1, 1,1,0,0);
        step("blink_f2",   0,0,0,0,0,1, 1,0,0,0);
        step("blink_f3",   0,0,0,0,0,1, 1,0,0,0);
        step("pause_go",   0,0,1,1,0,0, 1,0,0,0);
        step("blink_f4",   0,0,0,0,0,1, 1,1,0,0);
        step("unpause",    0,1,0,0,0,0, 1,0,1,0);

        // Done outside REGEN ignored; needs a fresh pulse
        step("stale_done", 0,0,0,0,1,0, 1,0,1,0);
        step("lvl_cmpl",   0,0,0,1,0,0, 3,1,0,1);
        step("regen3",     0,0,0,0,0,0, 3,1,0,0);
        for (int i = 0; i < 4; i++) step("regen3_f", 0,0,0,0,0,1, 3,1,0,0);
        step("no_done",    0,0,0,0,0,0, 3,1,0,0);
        step("fresh_done", 0,0,0,0,1,0, 3,1,0,0);
        step("to_run3",    0,0,0,0,0,0, 3,0,1,0);

        // Asynchronous reset in the middle of a regen_start pulse
        step("lvl_cmpl2",  0,0,0,1,0,0, 3,1,0,1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst",  0,0,0,0,0,0, 0,1,0,0);

        chk("sb_left", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/banner_ctrl.md
Name: banner_ctrl

Overview:
- Game-mode sequencer that drives the banner overlay renderer and gates the game logic.
- Tracks the game mode: init, running, paused, game over and level regeneration.
- Selects which banner is shown and enables the overlay; blinks the pause banner.
- Issues the level-regeneration request and enforces minimum on-screen times in frames.

Parameters:
- BLINK_FRAMES, 30, frames per half-period of the pause-banner blink
- MIN_REGEN_FRAMES, 60, minimum frames the regen banner is held, even if the level is ready earlier
- GAME_OVER_FRAMES, 120, frames after game over during which i_start is ignored
- NUM_IMAGES, 4, number of banners; sets the o_banner_num width

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at the start of each video frame
- i_start  in  1  one-cycle pulse, debounced start button
- i_pause  in  1  one-cycle pulse, debounced pause toggle
- i_game_over  in  1  one-cycle pulse from game logic: player lost
- i_lvl_complete  in  1  one-cycle pulse from game logic: level cleared
- i_regen_done  in  1  one-cycle pulse from level generator: new level ready
- o_banner_num  out  $clog2(NUM_IMAGES)  banner select: 0 init, 1 pause, 2 game over, 3 regen
- o_banner_enbl  out  1  overlay enable; when 0, game graphics are shown instead
- o_game_run  out  1  game-logic advance enable
- o_regen_start  out  1  one-cycle pulse requesting level generation

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - Reset values: state INIT, frame counter 0, blink phase 1, regen-done flag 0.
  - Outputs at reset: o_banner_num=0, o_banner_enbl=1, o_game_run=0, o_regen_start=0.
- Output timing:
  - Every output is decoded from registered state, so there is no input-to-output combinational path.
  - Outputs change in the cycle after the triggering input pulse is sampled.
- States and outputs (banner_num / banner_enbl / game_run):
  - INIT: 0 / 1 / 0
  - REGEN: 3 / 1 / 0
  - RUN: x / 0 / 1 (banner_num holds its last value)
  - PAUSE: 1 / blink phase / 0
  - GAME_OVER: 2 / 1 / 0
- Transitions:
  - INIT: i_start -> REGEN.
  - REGEN: exits to RUN once the done flag is set and frame_cnt >= MIN_REGEN_FRAMES.
  - RUN: i_game_over -> GAME_OVER; else i_lvl_complete -> REGEN; else i_pause -> PAUSE.
  - PAUSE: i_pause -> RUN. i_game_over and i_lvl_complete are ignored.
  - GAME_OVER: i_start -> INIT, accepted only when frame_cnt >= GAME_OVER_FRAMES; earlier i_start is dropped, not queued.
- o_regen_start:
  - High for exactly one cycle, the first cycle in REGEN after entry.
  - Entry is from INIT or from RUN.
- Done flag:
  - Set by i_regen_done while in REGEN, including in the o_regen_start cycle.
  - Cleared on entry to REGEN.
  - i_regen_done outside REGEN is ignored.
- Frame counter:
  - Cleared on every state change.
  - Increments on i_frame_start and saturates at its maximum.
  - Width is $clog2(max(MIN_REGEN_FRAMES, GAME_OVER_FRAMES, BLINK_FRAMES)+1).
- Blink:
  - In PAUSE, when i_frame_start arrives and frame_cnt == BLINK_FRAMES-1, the blink phase toggles and the counter clears.
  - Blink phase is set to 1 on entry to PAUSE.
- Simultaneous events:
  - In RUN, priority is game_over > lvl_complete > pause.
  - i_frame_start coincident with a state change: the counter clears and the frame is not counted.
- Unused input pulses in any state have no effect.
- Reset asserted mid-operation (e.g. during REGEN) returns to INIT immediately. A pending o_regen_start pulse is dropped.

Test Plan:
- Reset released, no stimulus -> banner_num=0, enbl=1, game_run=0, o_regen_start=0 indefinitely.
- MIN_REGEN_FRAMES=4:
  - i_start in INIT -> REGEN next cycle, o_regen_start high one cycle.
  - i_regen_done after 1 frame -> stays REGEN until the 4th i_frame_start, then RUN (enbl=0, game_run=1).
- RUN: i_game_over, i_lvl_complete and i_pause in the same cycle -> GAME_OVER (banner_num=2). i_start after 1 frame is ignored. With GAME_OVER_FRAMES=3, i_start after 3 frames -> INIT.
- BLINK_FRAMES=2, PAUSE entered -> enbl sequence 1,1,0,0,1 across successive frame pulses. i_pause -> RUN with enbl=0.
- RUN: i_lvl_complete -> REGEN, banner_num=3, one o_regen_start pulse. i_regen_done before entry to REGEN is ignored; the block remains in REGEN until a fresh done pulse.
- i_rst_n low mid-REGEN, asynchronously -> all outputs at reset values in the same cycle, without a clock edge.
